// File: rtl/lb_shiftreg_tx.sv
// lb_shiftreg_tx: 12-bit framed serial transmitter (start, 8 data, parity, 2 stop) with mid-bit shift strobe
module lb_shiftreg_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       shift_out,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [11:0] frame;
  logic [3:0] bit_cnt;
  logic [CW-1:0] clk_cnt;
  logic accept, bit_end;
  always_comb begin
    accept = state == IDLE && tx_valid;
    bit_end = state == SEND && clk_cnt == LAST;
    state_nx = accept ? SEND : (bit_end && bit_cnt == 4'd11) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Stop bits and the 1-fill leave frame at all-ones, so frame[0] also drives the idle-high line
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      frame <= 12'hFFF;
      bit_cnt <= 4'd0;
      clk_cnt <= '0;
    end else if (accept) begin
      frame <= {2'b11, PARITY_ODD ? ~^tx_data : ^tx_data, tx_data, 1'b0};
      bit_cnt <= 4'd0;
      clk_cnt <= '0;
    end else if (state == SEND) begin
      clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      frame <= bit_end ? {1'b1, frame[11:1]} : frame;
      bit_cnt <= bit_end ? bit_cnt + 4'd1 : bit_cnt;
    end
  assign tx_out = frame[0];
  assign tx_ready = state == IDLE;
  assign busy = state == SEND;
  assign shift_out = busy && clk_cnt == MID;
endmodule

// File: tb/tb_lb_shiftreg_tx.sv
// tb_lb_shiftreg_tx: checks three transmitter configurations against a frame/timing model and a loopback receiver
module tb_lb_shiftreg_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] valid = 3'b000;
  logic [7:0] data [3];
  logic [2:0] tx_out, shift_out, busy, ready;
  int total = 0;
  int bad = 0;
  logic [11:0] rx_word;

  always #5 clk = ~clk;

  lb_shiftreg_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_out(tx_out[0]), .shift_out(shift_out[0]), .busy(busy[0]));
  lb_shiftreg_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_out(tx_out[1]), .shift_out(shift_out[1]), .busy(busy[1]));
  lb_shiftreg_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b0)) dut_fast (
    .clk(clk), .reset(reset), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_out(tx_out[2]), .shift_out(shift_out[2]), .busy(busy[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] word(input int i, input logic [7:0] d);
    logic p;
    p = (^d) ^ (i == 1);
    return {2'b11, p, d, 1'b0};
  endfunction

  task automatic idle_chk(input int i, input string tag);
    chk({tag, "_tx_out"}, tx_out[i], 1);
    chk({tag, "_ready"}, ready[i], 1);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_shift"}, shift_out[i], 0);
  endtask

  // Sends one byte on instance i and checks every cycle of the frame; abort_k asserts reset at that frame cycle
  task automatic send(input int i, input logic [7:0] d, input bit hold, input int chg_k,
                      input logic [7:0] chg_d, input int abort_k, output logic [11:0] rx_o);
    int c, n;
    logic [11:0] exp, rx;
    c = (i == 2) ? 2 : 4;
    exp = word(i, d);
    rx = 12'h000;
    n = 0;
    rx_o = 12'h000;
    chk("ready_before_accept", ready[i], 1);
    valid[i] = 1'b1;
    data[i] = d;
    tick();
    if (!hold) valid[i] = 1'b0;
    for (int k = 0; k < 12 * c; k++) begin
      if (k == abort_k) begin
        reset = 1'b0;
        #1;
        idle_chk(i, "abort");
        return;
      end
      if (k == chg_k) data[i] = chg_d;
      chk("bit_value", tx_out[i], int'(exp[k / c]));
      chk("busy_in_frame", busy[i], 1);
      chk("ready_in_frame", ready[i], 0);
      chk("strobe_pos", shift_out[i], int'(k % c == c / 2));
      if (shift_out[i]) begin
        rx = {tx_out[i], rx[11:1]};
        n++;
      end
      tick();
    end
    chk("strobe_count", n, 12);
    chk("rx_word", rx, exp);
    chk("end_ready", ready[i], 1);
    chk("end_busy", busy[i], 0);
    chk("end_tx_out", tx_out[i], 1);
    rx_o = rx;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    tick();
    tick();
    for (int i = 0; i < 3; i++) idle_chk(i, "reset");
    reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      for (int i = 0; i < 3; i++) idle_chk(i, "idle");
    end
    send(0, 8'hA5, 1'b0, -1, 8'h00, -1, rx_word);
    chk("a5_even_word", rx_word, 12'hD4A);
    tick();
    send(0, 8'h00, 1'b0, -1, 8'h00, -1, rx_word);
    chk("zero_even_word", rx_word, 12'hC00);
    send(1, 8'h00, 1'b0, -1, 8'h00, -1, rx_word);
    chk("zero_odd_word", rx_word, 12'hE00);
    send(0, 8'h3C, 1'b1, 20, 8'h81, -1, rx_word);
    chk("b2b_first_word", rx_word, word(0, 8'h3C));
    send(0, 8'h81, 1'b0, 10, 8'hFF, -1, rx_word);
    chk("b2b_second_word", rx_word, word(0, 8'h81));
    send(0, 8'h77, 1'b0, -1, 8'h00, 21, rx_word);
    tick();
    idle_chk(0, "held_reset");
    reset = 1'b1;
    tick();
    idle_chk(0, "post_reset");
    send(0, 8'h5A, 1'b0, -1, 8'h00, -1, rx_word);
    chk("after_reset_word", rx_word, word(0, 8'h5A));
    send(2, 8'hA5, 1'b0, -1, 8'h00, -1, rx_word);
    chk("fast_a5_word", rx_word, 12'hD4A);
    for (int r = 0; r < 8; r++) begin
      int i, gap;
      logic [7:0] d;
      i = int'($urandom_range(0, 2));
      d = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_shift", shift_out[i], 0);
      end
      send(i, d, 1'b0, int'($urandom_range(0, 7)), 8'($urandom), -1, rx_word);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lb_shiftreg_tx.md
# lb_shiftreg_tx

Serial frame transmitter that pairs with the 12-bit loopback receive shift register. It accepts an 8-bit byte over a valid/ready handshake and builds a 12-bit frame: start bit, 8 data bits, parity bit and 2 stop bits. It shifts the frame out LSB-first, holding each bit for a programmable number of clocks. It also emits a mid-bit `shift_out` strobe, so a receive shift register driven from `tx_out` and `shift_out` ends each frame holding the complete 12-bit word.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit; legal range 2..65535; counter width is `$clog2(CLKS_PER_BIT)`.
- `PARITY_ODD`, default 0: 0 gives even parity, where the parity bit is `^tx_data`; 1 gives odd parity, where the parity bit is `~^tx_data`.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `tx_data` input, 8 bits: byte to send; sampled only on an accepted handshake.
- `tx_valid` input, 1 bit: request to send `tx_data`.
- `tx_ready` output, 1 bit: block can accept a byte; high only in IDLE.
- `tx_out` output, 1 bit: serial line; idles high.
- `shift_out` output, 1 bit: one-cycle strobe at the middle of each bit; connects to the receiver's `shift` input.
- `busy` output, 1 bit: a frame is in progress (SEND state).

## Operation
- Frame register: 12 bits, loaded as {1, 1, parity, `tx_data[7:0]`, 0}. Bit 0 is transmitted first.
- Registers:
  - `frame[11:0]`
  - `bit_cnt[3:0]`, counting 0..11
  - `clk_cnt`, counting 0..`CLKS_PER_BIT`-1
  - `state`
- **IDLE**
  - Outputs: `tx_out`=1, `tx_ready`=1, `busy`=0, `shift_out`=0.
  - When `tx_valid` and `tx_ready` are both high at a clock edge:
    - load `frame`;
    - clear `bit_cnt` and `clk_cnt`;
    - go to SEND.
- **SEND**
  - `tx_out` = `frame[0]`, registered.
  - `clk_cnt` increments every clock.
  - `shift_out` = 1 for exactly one cycle per bit, when `clk_cnt` == `CLKS_PER_BIT`/2 (integer division).
  - When `clk_cnt` == `CLKS_PER_BIT`-1:
    - `clk_cnt` goes to 0;
    - `frame` shifts right, filling with 1;
    - `bit_cnt` increments.
  - If `bit_cnt` == 11 at that same boundary, go to IDLE.
  - `tx_valid` and `tx_data` are ignored in SEND.
- Exactly 12 `shift_out` pulses occur per frame, never more and never fewer.
- **Reset** (asserted at any time, including mid-frame):
  - state goes to IDLE; the partial frame is discarded with no further strobes;
  - `tx_out`=1, `tx_ready`=1, `busy`=0, `shift_out`=0, `frame`=12'hFFF, counters=0.
- **Reset release:** first acceptance no earlier than the first rising edge after `reset` goes high.

## Timing
- **Acceptance:** occurs at edge E. From E+1, `tx_ready`=0, `busy`=1 and `tx_out`=0 (start bit).
- **Bit timing:** bit k drives `tx_out` during cycles E+1+k·`CLKS_PER_BIT` .. E+(k+1)·`CLKS_PER_BIT`.
- **Strobe:** `shift_out` for bit k is high in cycle E+1+k·`CLKS_PER_BIT`+`CLKS_PER_BIT`/2.
- **Frame length:** the frame occupies 12·`CLKS_PER_BIT` cycles. In cycle E+12·`CLKS_PER_BIT`+1, `tx_ready`=1, `busy`=0 and `tx_out`=1.
- **Back-to-back:** with `tx_valid` held high, the next start bit begins one cycle after `tx_ready` rises. This guarantees at least one idle high cycle between frames.
- **Data stability:** `tx_data` may change freely after the accepting edge; the frame is unaffected.
- **Output style:** no combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset values:** assert `reset` low, then release → `tx_out`=1, `tx_ready`=1, `busy`=0, `shift_out`=0, with no strobes while idle and `tx_valid`=0.
- **Even-parity loopback:** `CLKS_PER_BIT`=4, even parity, send 8'hA5 with `tx_out`→`data_in` and `shift_out`→`shift` of the receive register → required response:
  - exactly 12 strobes;
  - receiver `data_out` = 12'hD4A;
  - `busy` high for 48 cycles;
  - `tx_ready` back at E+49.
- **Parity selection:** send 8'h00 with `PARITY_ODD`=0 → receiver holds 12'hC00. Same byte with `PARITY_ODD`=1 → 12'hE00.
- **Back-to-back:** hold `tx_valid` high with 8'h3C, then 8'hFF; `tx_data` changes mid-frame to 8'h81 → required response:
  - first frame carries 8'h3C;
  - exactly one idle cycle with `tx_out`=1 separates the frames;
  - second frame carries the value present at its own acceptance.
- **Reset mid-frame:** assert `reset` during bit 5 → required response:
  - same cycle: `tx_out`=1, `busy`=0, `tx_ready`=1, `shift_out`=0;
  - after release, a new 8'h5A frame transmits correctly with 12 strobes.
- **Bit-width corner:** `CLKS_PER_BIT`=2 → each bit lasts 2 cycles, the strobe lands in the second cycle of each bit, and the frame takes 24 cycles.
